// File: rtl/cirno9_ram4ls_resp.sv
// Load/store SRAM responder: accepts word read/write requests, inserts WAIT_CYC wait states,
// then pulses ready with read data. Define CIRNO9_RAM4LS_ERR_EN to flag out-of-range addresses.
module cirno9_ram4ls_resp #(
  parameter int unsigned AW       = 10,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_sram_ren,
  input  logic [3:0]  i_sram_wen,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_wdat,
  output logic [31:0] o_sram_rdat,
  output logic        o_hs_ram4ls_rdy,
  output logic        o_err
);

  localparam int unsigned Depth = 2 ** AW;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [3:0]    wen_q, wen_d;
  logic [31:0]   wdat_q, wdat_d;
  logic          oor_q, oor_d;
  logic          rdy_q, rdy_d;
  logic          err_q, err_d;
  logic [31:0]   rdat_q, rdat_d;
  logic [31:0]   mem_q [Depth];
  logic          req;
  logic          oor_in;
  logic          mem_we;
  logic          unused_adr;

  assign req = i_sram_ren | (|i_sram_wen);

`ifdef CIRNO9_RAM4LS_ERR_EN
  assign oor_in     = |i_adr[31:AW+2];
  assign unused_adr = ^i_adr[1:0];
`else
  // Upper address bits are ignored: the array wraps modulo its depth.
  assign oor_in     = 1'b0;
  assign unused_adr = ^{i_adr[31:AW+2], i_adr[1:0]};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    wen_d   = wen_q;
    wdat_d  = wdat_q;
    oor_d   = oor_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    rdat_d  = rdat_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          adr_d   = i_adr[AW+1:2];
          wen_d   = i_sram_wen;
          wdat_d  = i_wdat;
          oor_d   = oor_in;
          cnt_d   = 4'(WAIT_CYC);
          state_d = (WAIT_CYC > 0) ? StWait : StResp;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = StResp;
      end
      StResp: begin
        // Read returns the pre-write word; the write lands on the same edge.
        rdy_d   = 1'b1;
        err_d   = oor_q;
        rdat_d  = oor_q ? 32'h0 : mem_q[adr_q];
        mem_we  = (|wen_q) & ~oor_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      adr_q   <= '0;
      wen_q   <= 4'd0;
      wdat_q  <= 32'h0;
      oor_q   <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      wen_q   <= wen_d;
      wdat_q  <= wdat_d;
      oor_q   <= oor_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  // Array is not reset; writes only happen from StResp, so a reset mid-transaction drops them.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wen_q[b]) mem_q[adr_q][8*b +: 8] <= wdat_q[8*b +: 8];
      end
    end
  end

  assign o_sram_rdat     = rdat_q;
  assign o_hs_ram4ls_rdy = rdy_q;
  assign o_err           = err_q;

endmodule

// File: tb/tb_cirno9_ram4ls_resp.sv
// Randomized self-checking bench for cirno9_ram4ls_resp against a word-array reference model.
module tb_cirno9_ram4ls_resp;

  localparam int AW = 10;
  localparam int W  = 2;
  localparam int Depth = 1 << AW;
`ifdef CIRNO9_RAM4LS_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ren = 1'b0;
  logic [3:0]  wen = 4'd0;
  logic [31:0] adr = 32'h0;
  logic [31:0] wdat = 32'h0;
  logic [31:0] rdat;
  logic        rdy;
  logic        err;

  cirno9_ram4ls_resp #(.AW(AW), .WAIT_CYC(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_sram_ren      (ren),
    .i_sram_wen      (wen),
    .i_adr           (adr),
    .i_wdat          (wdat),
    .o_sram_rdat     (rdat),
    .o_hs_ram4ls_rdy (rdy),
    .o_err           (err)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_fail = 0;
  logic [31:0] mem_m [Depth];
  bit          known [Depth];
  logic [31:0] last_rdat = 32'h0;
  bit          last_known = 1'b0;

  // One transaction: inputs are applied just after an edge, the next edge samples them, and
  // rdy must be high only after the (W+2)-th edge. Inputs are left applied on return so the
  // caller either issues the next request back-to-back or drops them with idle().
  task automatic txn(input logic r, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d, input string nm);
    int          idx;
    bit          oor;
    logic [31:0] exp;
    bit          exp_known;
    logic        exp_rdy;
    idx       = int'(a[AW+1:2]);
    oor       = ErrEn && (a[31:AW+2] != 0);
    exp       = oor ? 32'h0 : mem_m[idx];
    exp_known = oor || known[idx];
    if (!oor && w != 4'd0) begin
      for (int b = 0; b < 4; b++) if (w[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
      if (w == 4'hF) known[idx] = 1'b1;
    end
    ren = r; wen = w; adr = a; wdat = d;
    for (int k = 1; k <= W + 2; k++) begin
      @(posedge clk); #1;
      exp_rdy = (k == W + 2);
      n_vec++;
      if (rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL %s rdy edge %0d: got %b want %b", nm, k, rdy, exp_rdy);
      end
      if (k < W + 2) begin
        n_vec++;
        if (err !== 1'b0) begin
          n_fail++;
          $display("FAIL %s err idle edge %0d: got %b want 0", nm, k, err);
        end
        if (k == 1 && last_known) begin
          n_vec++;
          if (rdat !== last_rdat) begin
            n_fail++;
            $display("FAIL %s rdat hold: got %h want %h", nm, rdat, last_rdat);
          end
        end
      end else begin
        n_vec++;
        if (err !== oor) begin
          n_fail++;
          $display("FAIL %s err: got %b want %b", nm, err, oor);
        end
        if (exp_known) begin
          n_vec++;
          if (rdat !== exp) begin
            n_fail++;
            $display("FAIL %s rdat: got %h want %h", nm, rdat, exp);
          end
        end
      end
    end
    last_rdat  = exp;
    last_known = exp_known;
  endtask

  task automatic idle(input int n);
    ren = 1'b0; wen = 4'd0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle rdy: got %b want 0", rdy);
      end
    end
  endtask

  task automatic check_word(input string nm, input logic [31:0] want);
    n_vec++;
    if (rdat !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, rdat, want);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (rdy !== 1'b0 || err !== 1'b0 || rdat !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: got rdy=%b err=%b rdat=%h want 0/0/0", rdy, err, rdat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    last_rdat  = 32'h0;
    last_known = 1'b1;
  endtask

  task automatic test_latency_read;
    txn(1'b1, 4'd0, 32'h0000_0010, 32'h0, "lat_read");
    idle(1);
  endtask

  task automatic test_byte_write;
    txn(1'b0, 4'hF, 32'h20, 32'hDEADBEEF, "bw_full");
    txn(1'b0, 4'b0010, 32'h20, 32'h0000_5500, "bw_lane1");
    txn(1'b1, 4'd0, 32'h20, 32'h0, "bw_read");
    check_word("bw_value", 32'hDEAD55EF);
    idle(1);
  endtask

  task automatic test_back_to_back;
    txn(1'b0, 4'hF, 32'h40, 32'h12345678, "b2b_wr");
    txn(1'b1, 4'd0, 32'h40, 32'h0, "b2b_rd");
    check_word("b2b_value", 32'h12345678);
    idle(1);
  endtask

  task automatic test_rmw;
    txn(1'b1, 4'hF, 32'h40, 32'hA5A5A5A5, "rmw");
    check_word("rmw_old", 32'h12345678);
    txn(1'b1, 4'd0, 32'h40, 32'h0, "rmw_rd");
    check_word("rmw_new", 32'hA5A5A5A5);
    idle(1);
  endtask

  task automatic test_reset_mid;
    txn(1'b0, 4'hF, 32'h80, 32'hFFFFFFFF, "rm_wr");
    idle(1);
    ren = 1'b0; wen = 4'hF; adr = 32'h80; wdat = 32'h0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    wen = 4'd0;
    #1;
    n_vec++;
    if (rdy !== 1'b0 || rdat !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid outputs: got rdy=%b rdat=%h want 0/0", rdy, rdat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    last_rdat  = 32'h0;
    last_known = 1'b1;
    txn(1'b1, 4'd0, 32'h80, 32'h0, "rm_rd");
    check_word("rm_value", 32'hFFFFFFFF);
    idle(1);
  endtask

  task automatic test_out_of_range;
    txn(1'b0, 4'hF, 32'h4, 32'h22222222, "oor_pre");
    txn(1'b0, 4'hF, 32'h0000_1004, 32'h11111111, "oor_wr");
    txn(1'b1, 4'd0, 32'h4, 32'h0, "oor_rd");
    check_word("oor_value", ErrEn ? 32'h22222222 : 32'h11111111);
    idle(1);
  endtask

  task automatic test_random;
    logic        r;
    logic [3:0]  w;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) txn(1'b0, 4'hF, 32'(i * 4), $urandom, "rnd_fill");
    for (int i = 0; i < 60; i++) begin
      w = 4'($urandom_range(0, 15));
      r = 1'($urandom_range(0, 1));
      if (w == 4'd0) r = 1'b1;
      a = {($urandom_range(0, 7) == 0) ? 20'($urandom) : 20'h0,
           6'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      txn(r, w, a, $urandom, "rnd");
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_latency_read();
    test_byte_write();
    test_back_to_back();
    test_rmw();
    test_reset_mid();
    test_out_of_range();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/cirno9_ram4ls_resp.md
Name: cirno9_ram4ls_resp

Overview:
- Load/store memory responder: the slave end of the core's SRAM request/ready handshake.
- Accepts word read/write requests, inserts a programmable number of wait states, performs the access on an internal word array, then pulses ready with the read data.
- Sits beside cirno9_core in place of a zero-wait SRAM, for wait-state and latency-tolerance testing of the core's load/store path.

Parameters:
- AW, 10, word-address width; depth = 2**AW words (4 KiB at default).
- WAIT_CYC, 2, wait states inserted before completion; legal range 0..15.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- i_sram_ren  input  1  read request
- i_sram_wen  input  4  byte write enables; bit n writes byte lane n (i_wdat[8n+7:8n])
- i_adr  input  32  byte address; bits [1:0] ignored
- i_wdat  input  32  write data
- o_sram_rdat  output  32  read data, valid only in the o_hs_ram4ls_rdy cycle
- o_hs_ram4ls_rdy  output  1  completion pulse
- o_err  output  1  access-error flag, valid with o_hs_ram4ls_rdy

Behaviour:
- Request present = i_sram_ren | (|i_sram_wen).
- Initiator holds ren/wen/adr/wdat stable until it sees rdy. Responder samples them only in IDLE.
- Reset: state IDLE, counter 0, o_hs_ram4ls_rdy=0, o_err=0, o_sram_rdat=0. Memory array is not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On a request, latch adr[AW+1:2], wen, wdat, ren and the range check, and load the counter with WAIT_CYC.
  - Go to WAIT if WAIT_CYC>0, else to RESP.
- WAIT: decrement the counter each cycle; go to RESP when the counter reaches 1.
- RESP:
  - Perform the access from the latched values.
  - Drive rdy=1 for exactly one cycle, then return to IDLE.
- Latency: request sampled at edge N; rdy is high in the cycle after edge N+WAIT_CYC+1 (1 cycle when WAIT_CYC=0).
- Back-to-back: IDLE can accept a new request on the edge that ends the rdy cycle. The initiator must have changed or dropped the request by then, otherwise it is taken as a new request. Minimum spacing between rdy pulses = WAIT_CYC+2 cycles.
- Write: only enabled byte lanes are updated; other lanes keep their values.
- Read: o_sram_rdat = latched word, registered so it is valid in the rdy cycle; it holds its value after rdy.
- ren and wen both set: read-before-write. rdat returns the pre-write word and the write is then committed.
- A write-only request returns rdat = pre-write word (do not care for the initiator).
- Reset asserted mid-transaction: the FSM goes to IDLE immediately and any pending write is dropped (no partial commit). A write already committed in RESP stays.
- Request deassertion during WAIT is a protocol violation: the transaction still completes using the latched values.

Optional Feature:
- Macro: CIRNO9_RAM4LS_ERR_EN.
- Defined:
  - A request with i_adr[31:AW+2] != 0 is out of range.
  - The transaction still takes the full latency, but no write is committed and rdat=0.
  - o_err=1 during the rdy cycle; o_err=0 otherwise.
- Not defined: upper address bits are ignored (address wraps modulo depth), and o_err is tied to 0.

Test Plan:
- Reset, then read at 0x0000_0010 with WAIT_CYC=2 → rdy high exactly 4 cycles after the sample edge, high for one cycle, o_err=0.
- Write wen=4'hF, adr 0x20, wdat 0xDEADBEEF; then write wen=4'b0010, wdat 0x0000_5500; then read 0x20 → rdat 0xDEAD55EF.
- Write-read back-to-back to 0x40 (data 0x12345678), no idle gap → second request accepted the edge after the first rdy; rdat 0x12345678; rdy pulses 4 cycles apart.
- Request with ren=1 and wen=4'hF at 0x40 (old 0x12345678, wdat 0xA5A5A5A5) → rdat 0x12345678; a following read returns 0xA5A5A5A5.
- Write 0xFFFFFFFF to 0x80, then a second write to 0x80 with rst_n pulsed low during its WAIT → no rdy for that write, FSM in IDLE; a following read of 0x80 returns 0xFFFFFFFF.
- Write 0x11111111 to 0x0000_1004 (out of range at AW=10):
  - with CIRNO9_RAM4LS_ERR_EN: o_err=1 with rdy, and word 1 is unchanged;
  - without it: word 1 reads back 0x11111111.
